// File: rtl/display_scan.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | display_scan: multiplexed 7-segment scanner with blanking gap and per-frame latch. |
// | Optional leading-zero blanking via `define SCAN_LZB_EN.  Rev 1.0                  |
// +-----------------------------------------------------------------------------------+
module display_scan #(
  parameter int DIGITS       = 4,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  tick_in,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_done
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [IW-1:0] C_LAST_IDX = IW'(DIGITS - 1);
  localparam logic [CW-1:0] C_LAST_CNT = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       index_q, index_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] latch_q, latch_d;
  logic [DIGITS-1:0]   dp_latch_q, dp_latch_d;
  logic [IW-1:0]       index_next;
  logic [3:0]          cur_digit;
  logic                blank_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0:    seg_decode = 7'h3F;
      4'h1:    seg_decode = 7'h06;
      4'h2:    seg_decode = 7'h5B;
      4'h3:    seg_decode = 7'h4F;
      4'h4:    seg_decode = 7'h66;
      4'h5:    seg_decode = 7'h6D;
      4'h6:    seg_decode = 7'h7D;
      4'h7:    seg_decode = 7'h07;
      4'h8:    seg_decode = 7'h7F;
      4'h9:    seg_decode = 7'h6F;
      4'hA:    seg_decode = 7'h77;
      4'hB:    seg_decode = 7'h7C;
      4'hC:    seg_decode = 7'h39;
      4'hD:    seg_decode = 7'h5E;
      4'hE:    seg_decode = 7'h79;
      default: seg_decode = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    cnt_d      = cnt_q;
    latch_d    = latch_q;
    dp_latch_d = dp_latch_q;
    frame_done = 1'b0;
    index_next = (index_q == C_LAST_IDX) ? '0 : index_q + 1'b1;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          index_d = C_LAST_IDX;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_LAST_CNT) begin
            state_d = ST_SHOW;
            index_d = index_next;
            // Frame data is captured only when the scan wraps, so a frame never tears.
            if (index_next == '0) begin
              latch_d    = digits_in;
              dp_latch_d = dp_in;
            end
          end
        end
        ST_SHOW: begin
          if (tick_in) begin
            state_d    = ST_BLANK;
            cnt_d      = '0;
            frame_done = (index_q == C_LAST_IDX) && !reset;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      cnt_q      <= '0;
      latch_q    <= '0;
      dp_latch_q <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      cnt_q      <= cnt_d;
      latch_q    <= latch_d;
      dp_latch_q <= dp_latch_d;
    end
  end

`ifdef SCAN_LZB_EN
  // zero_above[k]: latched digits k..DIGITS-1 are all zero.
  logic [DIGITS-1:0] zero_above;
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      all_zero      = all_zero && (latch_q[4*k +: 4] == 4'h0);
      zero_above[k] = all_zero;
    end
  end
  assign blank_digit = (index_q != '0) && zero_above[index_q] && !dp_latch_q[index_q];
`else
  assign blank_digit = 1'b0;
`endif

  always_comb begin
    seg_out   = 7'h7F;
    dp_out    = 1'b1;
    an_out    = '1;
    cur_digit = latch_q[{index_q, 2'b00} +: 4];
    if (state_q == ST_SHOW && !blank_digit) begin
      an_out[index_q] = 1'b0;
      seg_out         = ~seg_decode(cur_digit);
      dp_out          = ~dp_latch_q[index_q];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | tb_display_scan: table-driven self-checking bench for display_scan.  Rev 1.0      |
// +-----------------------------------------------------------------------------------+
module tb_display_scan;

  localparam int DIGITS       = 4;
  localparam int BLANK_CYCLES = 4;
  localparam int HOLD         = 26;

  logic        clock_in = 1'b0;
  logic        reset;
  logic        tick_in;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  display_scan #(
    .DIGITS       (DIGITS),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .tick_in    (tick_in),
    .enable     (enable),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  always #5 clock_in = ~clock_in;

  // digits/dp are driven while this slot's digit is on screen; the rest is expected output.
  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpo;
    logic        fd;
  } vec_t;

  vec_t vecs[16];
  vec_t tail[8];

`ifdef SCAN_LZB_EN
  localparam logic [3:0] LZ_AN2  = 4'hF;
  localparam logic [3:0] LZ_AN3  = 4'hF;
  localparam logic [6:0] LZ_SEG  = 7'h7F;
`else
  localparam logic [3:0] LZ_AN2  = 4'b1011;
  localparam logic [3:0] LZ_AN3  = 4'b0111;
  localparam logic [6:0] LZ_SEG  = 7'h40;
`endif

  task automatic cyc();
    @(posedge clock_in);
    #2;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_dark(input string name);
    chk(name, {3'h0, an_out, seg_out, dp_out, frame_done}, {3'h0, 4'hF, 7'h7F, 1'b1, 1'b0});
  endtask

  // Entered just after the edge that moved the DUT into BLANK; leaves at the same point.
  task automatic slot(input string name, input vec_t v);
    logic dark_ok;
    dark_ok = 1'b1;
    for (int i = 0; i < BLANK_CYCLES; i++) begin
      if (i > 0) cyc();
      if ({an_out, seg_out, dp_out, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) dark_ok = 1'b0;
    end
    chk({name, " blank gap"}, {15'h0, dark_ok}, 16'h0001);
    cyc();
    chk({name, " shown"}, {4'h0, an_out, seg_out, dp_out}, {4'h0, v.an, v.seg, v.dpo});
    digits_in = v.digits;
    dp_in     = v.dp;
    repeat (HOLD) cyc();
    chk({name, " held"}, {4'h0, an_out, seg_out, dp_out}, {4'h0, v.an, v.seg, v.dpo});
    tick_in = 1'b1;
    #1;
    chk({name, " frame_done"}, {15'h0, frame_done}, {15'h0, v.fd});
    cyc();
    tick_in = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'h1234, 4'h0, 4'b1110, 7'h19, 1'b1, 1'b0};
    vecs[1]  = '{16'hABCD, 4'h4, 4'b1101, 7'h30, 1'b1, 1'b0};
    vecs[2]  = '{16'hABCD, 4'h4, 4'b1011, 7'h24, 1'b1, 1'b0};
    vecs[3]  = '{16'hABCD, 4'h4, 4'b0111, 7'h79, 1'b1, 1'b1};
    vecs[4]  = '{16'hABCD, 4'h4, 4'b1110, 7'h21, 1'b1, 1'b0};
    vecs[5]  = '{16'h9EF0, 4'h0, 4'b1101, 7'h46, 1'b1, 1'b0};
    vecs[6]  = '{16'h9EF0, 4'h0, 4'b1011, 7'h03, 1'b0, 1'b0};
    vecs[7]  = '{16'h9EF0, 4'h0, 4'b0111, 7'h08, 1'b1, 1'b1};
    vecs[8]  = '{16'h9EF0, 4'h0, 4'b1110, 7'h40, 1'b1, 1'b0};
    vecs[9]  = '{16'h5678, 4'h0, 4'b1101, 7'h0E, 1'b1, 1'b0};
    vecs[10] = '{16'h5678, 4'h0, 4'b1011, 7'h06, 1'b1, 1'b0};
    vecs[11] = '{16'h5678, 4'h0, 4'b0111, 7'h10, 1'b1, 1'b1};
    vecs[12] = '{16'h5678, 4'h0, 4'b1110, 7'h00, 1'b1, 1'b0};
    vecs[13] = '{16'h5678, 4'h0, 4'b1101, 7'h78, 1'b1, 1'b0};
    vecs[14] = '{16'h5678, 4'h0, 4'b1011, 7'h02, 1'b1, 1'b0};
    vecs[15] = '{16'h5678, 4'h0, 4'b0111, 7'h12, 1'b1, 1'b1};
    // After a mid-frame reset: fresh 1234 frame, then the leading-zero frame 0070.
    tail[0]  = '{16'h0070, 4'h0, 4'b1110, 7'h19, 1'b1, 1'b0};
    tail[1]  = '{16'h0070, 4'h0, 4'b1101, 7'h30, 1'b1, 1'b0};
    tail[2]  = '{16'h0070, 4'h0, 4'b1011, 7'h24, 1'b1, 1'b0};
    tail[3]  = '{16'h0070, 4'h0, 4'b0111, 7'h79, 1'b1, 1'b1};
    tail[4]  = '{16'h0070, 4'h0, 4'b1110, 7'h40, 1'b1, 1'b0};
    tail[5]  = '{16'h0070, 4'h0, 4'b1101, 7'h78, 1'b1, 1'b0};
    tail[6]  = '{16'h0070, 4'h0, LZ_AN2,  LZ_SEG, 1'b1, 1'b0};
    tail[7]  = '{16'h0070, 4'h0, LZ_AN3,  LZ_SEG, 1'b1, 1'b1};

    reset     = 1'b1;
    enable    = 1'b0;
    tick_in   = 1'b0;
    digits_in = 16'h1234;
    dp_in     = 4'h0;
    cyc();
    cyc();
    chk_dark("reset state");
    reset = 1'b0;
    cyc();
    chk_dark("idle while disabled");

    enable = 1'b1;
    cyc();
    for (int i = 0; i < 16; i++) slot($sformatf("vec%0d", i), vecs[i]);

    // Tick landing in BLANK must not restart the gap or advance the digit.
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
    cyc();
    cyc();
    chk_dark("blank tick ignored, still dark");
    cyc();
    chk("blank tick ignored, digit0 on time", {4'h0, an_out, seg_out, dp_out},
        {4'h0, 4'b1110, 7'h00, 1'b1});
    repeat (40) cyc();
    chk("slot held until next tick", {4'h0, an_out, seg_out, dp_out},
        {4'h0, 4'b1110, 7'h00, 1'b1});

    // Disable wins over a simultaneous tick.
    tick_in = 1'b1;
    enable  = 1'b0;
    #1;
    chk("no frame_done on disable", {15'h0, frame_done}, 16'h0000);
    cyc();
    tick_in = 1'b0;
    chk_dark("disable goes dark");
    repeat (3) cyc();
    chk_dark("stays idle while disabled");

    enable = 1'b1;
    cyc();
    slot("restart d0", '{16'h1234, 4'h0, 4'b1110, 7'h00, 1'b1, 1'b0});
    slot("restart d1", '{16'h1234, 4'h0, 4'b1101, 7'h78, 1'b1, 1'b0});
    repeat (BLANK_CYCLES) cyc();
    chk("digit2 before reset", {4'h0, an_out, seg_out, dp_out}, {4'h0, 4'b1011, 7'h02, 1'b1});
    reset = 1'b1;
    cyc();
    chk_dark("reset during show");
    reset = 1'b0;
    cyc();
    for (int i = 0; i < 8; i++) slot($sformatf("tail%0d", i), tail[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
